// File: rtl/act_quant_child.sv
// Post-bias activation and requantisation stage: activation, unsigned scale, round-half-up
// right shift and signed saturation in a 3-stage valid-tagged pipeline.
module act_quant_child #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SCALE_WIDTH = 16,
  parameter int unsigned OUT_WIDTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [DATA_WIDTH-1:0]  act_data_in,
  input  logic                          act_valid_in,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [1:0]                    cfg_mode,
  input  logic [SCALE_WIDTH-1:0]        cfg_scale,
  input  logic [5:0]                    cfg_shift,
  output logic signed [OUT_WIDTH-1:0]   act_q_data_out,
  output logic                          act_q_valid_out,
  output logic                          act_busy
);

  localparam int unsigned ProdWidth = DATA_WIDTH + SCALE_WIDTH + 1;
  localparam int unsigned RndWidth  = ProdWidth + 1;
  localparam logic [5:0]  MaxShift  = 6'd48;

  localparam logic signed [RndWidth-1:0] SatHi =
      {{(RndWidth - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [RndWidth-1:0] SatLo = ~SatHi;
  localparam logic signed [OUT_WIDTH-1:0] OutMax = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OutMin = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    ModeIdent = 2'b00,
    ModeRelu  = 2'b01,
    ModeLeaky = 2'b10,
    ModeRsvd  = 2'b11
  } mode_e;

  // Configuration
  mode_e                   mode_q;
  logic [SCALE_WIDTH-1:0]  scale_q;
  logic [5:0]              shift_q;
  logic                    cfg_commit;
  logic [5:0]              shift_clamped;

  // Pipeline state
  logic signed [DATA_WIDTH-1:0] a1_q, a1_d;
  logic                         v1_q;
  logic signed [ProdWidth-1:0]  p_q, p_d;
  logic                         v2_q;
  logic signed [OUT_WIDTH-1:0]  out_q, out_d;
  logic                         v3_q;

  // Stage 3 intermediates
  logic signed [ProdWidth-1:0]  a1_ext;
  logic signed [ProdWidth-1:0]  scale_ext;
  logic signed [RndWidth-1:0]   p_ext;
  logic signed [RndWidth-1:0]   rnd;
  logic signed [RndWidth-1:0]   sum;
  logic signed [RndWidth-1:0]   r;

  // Config may only change while nothing is in flight or arriving.
  assign cfg_ready     = !act_valid_in && !v1_q && !v2_q && !v3_q;
  assign cfg_commit    = cfg_valid && cfg_ready;
  assign shift_clamped = (cfg_shift > MaxShift) ? MaxShift : cfg_shift;

  // Stage 1: activation
  always_comb begin
    a1_d = act_data_in;
    unique case (mode_q)
      ModeIdent: a1_d = act_data_in;
      ModeRelu:  a1_d = act_data_in[DATA_WIDTH-1] ? '0 : act_data_in;
      ModeLeaky: a1_d = act_data_in[DATA_WIDTH-1] ? (act_data_in >>> 3) : act_data_in;
      ModeRsvd:  a1_d = act_data_in;
      default:   a1_d = act_data_in;
    endcase
  end

  // Stage 2: signed multiply by zero-extended scale; full width, cannot overflow
  always_comb begin
    a1_ext    = {{(ProdWidth - DATA_WIDTH){a1_q[DATA_WIDTH-1]}}, a1_q};
    scale_ext = {{(ProdWidth - SCALE_WIDTH){1'b0}}, scale_q};
    p_d       = a1_ext * scale_ext;
  end

  // Stage 3: round half toward +inf, arithmetic shift, saturate
  always_comb begin
    p_ext = {p_q[ProdWidth-1], p_q};
    rnd   = '0;
    if (shift_q != 6'd0) begin
      rnd = RndWidth'(1) << (shift_q - 6'd1);
    end
    sum = p_ext + rnd;
    r   = sum >>> shift_q;
    if (r > SatHi) begin
      out_d = OutMax;
    end else if (r < SatLo) begin
      out_d = OutMin;
    end else begin
      out_d = r[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= ModeIdent;
      scale_q <= SCALE_WIDTH'(1);
      shift_q <= '0;
      a1_q    <= '0;
      v1_q    <= 1'b0;
      p_q     <= '0;
      v2_q    <= 1'b0;
      out_q   <= '0;
      v3_q    <= 1'b0;
    end else begin
      v1_q <= act_valid_in;
      v2_q <= v1_q;
      v3_q <= v2_q;
      // Data registers hold across bubbles so the output stays stable.
      if (act_valid_in) a1_q  <= a1_d;
      if (v1_q)         p_q   <= p_d;
      if (v2_q)         out_q <= out_d;
      if (cfg_commit) begin
        mode_q  <= mode_e'(cfg_mode);
        scale_q <= cfg_scale;
        shift_q <= shift_clamped;
      end
    end
  end

  assign act_q_data_out  = out_q;
  assign act_q_valid_out = v3_q;
  assign act_busy        = v1_q | v2_q | v3_q;

endmodule

// File: tb/tb_act_quant_child.sv
// Bench for act_quant_child: arithmetic reference model compared every cycle, plus directed
// sequences with hand-computed output lists.
module tb_act_quant_child;

  localparam int DW = 32;
  localparam int SW = 16;
  localparam int OW = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] act_data_in;
  logic                 act_valid_in;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [1:0]           cfg_mode;
  logic [SW-1:0]        cfg_scale;
  logic [5:0]           cfg_shift;
  logic signed [OW-1:0] act_q_data_out;
  logic                 act_q_valid_out;
  logic                 act_busy;

  act_quant_child #(
    .DATA_WIDTH (DW),
    .SCALE_WIDTH(SW),
    .OUT_WIDTH  (OW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .act_data_in    (act_data_in),
    .act_valid_in   (act_valid_in),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_mode       (cfg_mode),
    .cfg_scale      (cfg_scale),
    .cfg_shift      (cfg_shift),
    .act_q_data_out (act_q_data_out),
    .act_q_valid_out(act_q_valid_out),
    .act_busy       (act_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  longint got[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Floor division by 2^s.
  function automatic longint fdiv2(input longint a, input int s);
    longint d;
    d = longint'(1) << s;
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic longint qmodel(input longint x, input int mode, input longint scale,
                                    input int shift);
    longint a, p, r, hi, lo;
    a = x;
    if (x < 0 && mode == 1) a = 0;
    if (x < 0 && mode == 2) a = fdiv2(x, 3);
    p = a * scale;
    if (shift == 0) r = p;
    else r = fdiv2(p + (longint'(1) << (shift - 1)), shift);
    hi = (longint'(1) << (OW - 1)) - 1;
    lo = -hi - 1;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

  // Reference: result computed whole at entry, then delayed three edges.
  int     m_mode, m_shift;
  longint m_scale;
  bit     m_v1, m_v2, m_v3;
  longint m_d1, m_d2, m_d3;
  bit     started = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      started <= 1'b1;
      m_mode  <= 0;
      m_scale <= 1;
      m_shift <= 0;
      m_v1 <= 0; m_v2 <= 0; m_v3 <= 0;
      m_d1 <= 0; m_d2 <= 0; m_d3 <= 0;
    end else begin
      m_v1 <= act_valid_in;
      m_v2 <= m_v1;
      m_v3 <= m_v2;
      if (act_valid_in) m_d1 <= qmodel(act_data_in, m_mode, m_scale, m_shift);
      m_d2 <= m_d1;
      m_d3 <= m_d2;
      if (cfg_valid && !act_valid_in && !(m_v1 || m_v2 || m_v3)) begin
        m_mode  <= int'(cfg_mode);
        m_scale <= longint'(cfg_scale);
        m_shift <= (cfg_shift > 6'd48) ? 48 : int'(cfg_shift);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("valid_out", act_q_valid_out, m_v3);
      check("data_out", act_q_data_out, m_d3);
      check("busy", act_busy, m_v1 || m_v2 || m_v3);
      check("cfg_ready", cfg_ready, !act_valid_in && !(m_v1 || m_v2 || m_v3));
      if (act_q_valid_out) got.push_back(act_q_data_out);
    end
  end

  task automatic send(input logic v, input int d);
    act_valid_in = v;
    act_data_in  = d;
    @(posedge clk);
    #1;
    act_valid_in = 1'b0;
    act_data_in  = 0;
  endtask

  task automatic flush();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic commit(input int mode, input int scale, input int shift);
    int n;
    n = 0;
    cfg_mode  = mode[1:0];
    cfg_scale = scale[SW-1:0];
    cfg_shift = shift[5:0];
    cfg_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!cfg_ready && n < 50);
    if (!cfg_ready) check("commit_timeout", 0, 1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic expect_outs(input string name, input int n, input int e0, input int e1,
                             input int e2);
    int e[3];
    e = '{e0, e1, e2};
    check($sformatf("%s_count", name), got.size(), n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_%0d", name, i), (i < got.size()) ? got[i] : -9999, e[i]);
    end
    got.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int lows;
    rst = 1'b1;
    act_valid_in = 1'b0;
    act_data_in  = 0;
    cfg_valid = 1'b0;
    cfg_mode  = 2'b00;
    cfg_scale = '0;
    cfg_shift = '0;

    check("model_sat_hi", qmodel(300, 0, 1, 0), 127);
    check("model_sat_lo", qmodel(-300, 0, 1, 0), -128);
    check("model_leaky", qmodel(-17, 2, 1, 0), -3);
    check("model_half_up", qmodel(-1, 0, 3, 1), -1);
    check("model_relu_rnd", qmodel(5, 1, 3, 1), 8);
    check("model_relu_rnd2", qmodel(4, 1, 3, 1), 6);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy", act_busy, 0);
    check("reset_valid", act_q_valid_out, 0);
    check("reset_data", act_q_data_out, 0);
    got.delete();

    send(1, 5); send(1, 300); send(1, -300); flush();
    expect_outs("defaults", 3, 5, 127, -128);

    commit(1, 3, 1);
    send(1, -7); send(1, 5); send(1, 4); flush();
    expect_outs("relu", 3, 0, 8, 6);

    commit(2, 1, 0);
    send(1, -17); send(1, 9); flush();
    expect_outs("leaky", 2, -3, 9, 0);

    commit(0, 3, 1);
    send(1, -1); flush();
    expect_outs("half_up", 1, -1, 0, 0);

    commit(0, 2, 0);
    send(1, 10); send(1, 20); send(0, 0); send(1, 30); flush();
    expect_outs("bubble", 3, 20, 40, 60);

    // Config request arrives together with a sample and must wait for the drain.
    commit(0, 1, 0);
    lows = 0;
    act_valid_in = 1'b1;
    act_data_in  = 10;
    cfg_mode  = 2'b00;
    cfg_scale = 4;
    cfg_shift = 0;
    cfg_valid = 1'b1;
    @(negedge clk);
    if (!cfg_ready) lows++;
    @(posedge clk);
    #1;
    act_valid_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cfg_ready) break;
      lows++;
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    check("blocked_ready_low", lows, 4);
    send(1, 10); flush();
    expect_outs("blocked", 2, 10, 40, 0);

    commit(0, 65535, 63);
    send(1, 32'sh7fffffff); send(1, 32'sh80000000); flush();
    commit(0, 0, 0);
    send(1, 12345); flush();
    expect_outs("extremes", 3, 0, 0, 0);

    commit(0, 2, 0);
    got.delete();
    send(1, 50); send(1, 60);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", act_busy, 0);
    flush();
    check("midrst_no_output", got.size(), 0);
    got.delete();
    send(1, 7); flush();
    expect_outs("after_rst", 1, 7, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
